// File: rtl/mult_div_unit.sv
// Iterative shift/add multiplier and restoring divider with start/busy/done handshake and HI/LO results.
// Define MULTDIV_DIV_EN to build the divide datapath; otherwise ops 10/11 finish with err=1.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_neg_res;
  logic               r_err_pend;
`ifdef MULTDIV_DIV_EN
  logic               r_is_div;
  logic               r_neg_rem;
`endif

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_bad;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  // Signed ops (op[0]==0) work on magnitudes; the sign is restored in FIX.
  assign w_a_neg = ~i_op[0] & i_a[WIDTH-1];
  assign w_b_neg = ~i_op[0] & i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

`ifdef MULTDIV_DIV_EN
  assign w_bad = i_op[1] & (i_b == '0);
`else
  assign w_bad = i_op[1];
`endif

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

`ifdef MULTDIV_DIV_EN
  logic [WIDTH:0]     w_rem;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;

  // Partial remainder stays below the divisor, so a borrow in bit WIDTH means "does not fit".
  assign w_rem      = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_rem - {1'b0, r_opnd};
  assign w_div_next = w_diff[WIDTH] ? {w_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
`endif

  always_comb begin
    w_prod   = r_neg_res ? -r_acc : r_acc;
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
`ifdef MULTDIV_DIV_EN
    if (r_is_div) begin
      w_res_lo = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_res_hi = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_neg_res  <= 1'b0;
      r_err_pend <= 1'b0;
`ifdef MULTDIV_DIV_EN
      r_is_div   <= 1'b0;
      r_neg_rem  <= 1'b0;
`endif
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_hi       <= '0;
      o_lo       <= '0;
    end else begin
      case (r_state)
        // DONE behaves like IDLE so a start in the done cycle is taken.
        S_IDLE, S_DONE: begin
          o_done <= 1'b0;
          o_err  <= 1'b0;
          if (i_start) begin
            o_busy     <= 1'b1;
            r_cnt      <= '0;
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_err_pend <= w_bad;
            r_state    <= w_bad ? S_FIX : S_RUN;
`ifdef MULTDIV_DIV_EN
            r_is_div   <= i_op[1];
            r_neg_rem  <= w_a_neg;
            if (i_op[1]) begin
              r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
              r_opnd <= w_b_mag;
            end else begin
              r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
              r_opnd <= w_a_mag;
            end
`else
            r_acc      <= {{WIDTH{1'b0}}, w_b_mag};
            r_opnd     <= w_a_mag;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
`ifdef MULTDIV_DIV_EN
          r_acc <= r_is_div ? w_div_next : w_mul_next;
`else
          r_acc <= w_mul_next;
`endif
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          o_busy  <= 1'b0;
          o_done  <= 1'b1;
          o_err   <= r_err_pend;
          r_state <= S_DONE;
          if (!r_err_pend) begin
            o_hi <= w_res_hi;
            o_lo <= w_res_lo;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
